// File: rtl/relu_quant_maxpool.sv
// ReLU + requantize-to-8-bit + 2x2/stride-2 max-pool, one independent lane per tree.
// Lanes share the stage-1 valid, column counter and row parity.
module relu_quant_maxpool #(
  parameter int NUM_TREES = 2,
  parameter int ROW_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_in,
  input  logic                      valid_in,
  input  logic [32*NUM_TREES-1:0]   pixel_vector_in,
  output logic                      valid_out,
  output logic [8*NUM_TREES-1:0]    pixel_vector_out
);

  localparam int HALF  = ROW_WIDTH / 2;
  localparam int COL_W = (ROW_WIDTH > 2) ? $clog2(ROW_WIDTH) : 1;
  localparam int LB_AW = (HALF > 1) ? $clog2(HALF) : 1;

  logic             v1_reg;
  logic             start1_reg;
  logic [COL_W-1:0] col_reg;
  logic             row_odd_reg;
  logic             valid_out_reg;

  logic [COL_W-1:0] cur_col;
  logic             cur_row_odd;
  logic             col_last;
  logic [LB_AW-1:0] lb_addr;

  // A registered start overrides whatever position the counters hold.
  always_comb begin
    cur_col     = start1_reg ? '0 : col_reg;
    cur_row_odd = start1_reg ? 1'b0 : row_odd_reg;
    col_last    = (cur_col == COL_W'(ROW_WIDTH - 1));
    lb_addr     = LB_AW'(cur_col >> 1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_reg        <= 1'b0;
      start1_reg    <= 1'b0;
      col_reg       <= '0;
      row_odd_reg   <= 1'b0;
      valid_out_reg <= 1'b0;
    end else begin
      v1_reg        <= valid_in;
      start1_reg    <= start_in & valid_in;
      valid_out_reg <= v1_reg & cur_col[0] & cur_row_odd;
      if (v1_reg) begin
        col_reg     <= col_last ? '0 : cur_col + 1'b1;
        row_odd_reg <= col_last ? ~cur_row_odd : cur_row_odd;
      end
    end
  end

  assign valid_out = valid_out_reg;

  generate
    for (genvar gi = 0; gi < NUM_TREES; gi++) begin : g_lane
      logic [31:0] x;
      logic [31:0] shifted;
      logic [7:0]  q_next;
      logic [7:0]  q_reg;
      logic [7:0]  hold_reg;
      logic [7:0]  out_reg;
      logic [7:0]  linebuf [HALF];
      logic [7:0]  h;
      logic [7:0]  lb_rd;
      logic [7:0]  pooled;

      always_comb begin
        x       = pixel_vector_in[32*gi +: 32];
        shifted = x >> SHIFT;
        if (x[31])
          q_next = 8'd0;
        else if (shifted > 32'd255)
          q_next = 8'hFF;
        else
          q_next = shifted[7:0];
        h      = (hold_reg > q_reg) ? hold_reg : q_reg;
        lb_rd  = linebuf[lb_addr];
        pooled = (lb_rd > h) ? lb_rd : h;
      end

      // Even rows only write the line buffer and odd rows only read it, so no collision.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          q_reg    <= '0;
          hold_reg <= '0;
          out_reg  <= '0;
          for (int i = 0; i < HALF; i++) linebuf[i] <= '0;
        end else begin
          if (valid_in) q_reg <= q_next;
          if (v1_reg) begin
            if (!cur_col[0])
              hold_reg <= q_reg;
            else if (!cur_row_odd)
              linebuf[lb_addr] <= h;
            else
              out_reg <= pooled;
          end
        end
      end

      assign pixel_vector_out[8*gi +: 8] = out_reg;
    end
  endgenerate

endmodule
